mult_seq_param: RTL and testbench

//  Parametrised sequential shift-add multiplier for the CPU mult/multu path; successor of the fixed 16-bit unit.

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_seq_counter.sv | 32 +++
 rtl/mult_seq_param.sv | 105 ++++++++++
 tb/tb_mult_seq_param.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants for the sequential multiplier family: FSM state encoding
// and the default operand width.
package mult_pkg;

  // 2-bit state encoding kept as plain constants so older blocks can share it
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int MULT_W_DEF = 16;

endpackage : mult_pkg

// File: rtl/mult_seq_counter.sv
// Iteration counter for the shift-add multiplier: loads the iteration count,
// decrements once per step and flags the last step and the exhausted state.
module mult_seq_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Load wins over decrement; never wrap below zero
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && !zero) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign last = (cnt_q == CNT_W'(1));
  assign zero = (cnt_q == '0);

endmodule : mult_seq_counter

// File: rtl/mult_seq_param.sv
// Parametrised sequential shift-add multiplier (unsigned or two's-complement).
// Operands are reduced to magnitudes, multiplied one bit per cycle, then the
// sign is re-applied in a single fix-up cycle before Done pulses.
module mult_seq_param
  import mult_pkg::*;
#(
  parameter int W = MULT_W_DEF,
  localparam int CNT_W = $clog2(W + 1)
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           St,
  input  logic           Signed,
  input  logic           Abort,
  input  logic [W-1:0]   Multiplicando,
  input  logic [W-1:0]   Multiplicador,
  output logic           Idle,
  output logic           Busy,
  output logic           Done,
  output logic [2*W-1:0] Produto
);

  logic [1:0]     state_q, state_d;
  logic           neg_q;
  logic [W-1:0]   mcand_q;
  logic [2*W:0]   acc_q;
  logic [2*W-1:0] produto_q;

  logic           start, step, cnt_last, cnt_zero;
  logic [W-1:0]   abs_a, abs_b;
  logic [W:0]     sum, upper;

  // Magnitudes; -2^(W-1) maps onto 2^(W-1), which is still exact as unsigned W bits
  assign abs_a = (Signed && Multiplicando[W-1]) ? -Multiplicando : Multiplicando;
  assign abs_b = (Signed && Multiplicador[W-1]) ? -Multiplicador : Multiplicador;

  assign start = (state_q == S_IDLE) && St;
  assign step  = (state_q == S_RUN) && !cnt_zero;

  // W+1-bit partial sum keeps the carry in ACC[2W]
  assign sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, mcand_q};
  assign upper = acc_q[0] ? sum : acc_q[2*W:W];

  mult_seq_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (start),
    .load_val (CNT_W'(W)),
    .dec      (step),
    .last     (cnt_last),
    .zero     (cnt_zero)
  );

  // Next-state logic; Abort only matters while an operation is in flight
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE: if (St) state_d = S_RUN;
      S_RUN: begin
        if (Abort)                      state_d = S_IDLE;
        else if (cnt_last || cnt_zero)  state_d = S_FIX;
      end
      S_FIX:  state_d = Abort ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: latch operands on accept, shift-add while running, publish in FIX
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      produto_q <= '0;
    end else begin
      if (start) begin
        neg_q   <= Signed & (Multiplicando[W-1] ^ Multiplicador[W-1]);
        mcand_q <= abs_a;
        acc_q   <= {{(W+1){1'b0}}, abs_b};
      end else if (step) begin
        acc_q <= {1'b0, upper, acc_q[W-1:1]};
      end
      // Produto changes only here, so partial products are never exposed
      if (state_q == S_FIX && !Abort) begin
        produto_q <= neg_q ? -acc_q[2*W-1:0] : acc_q[2*W-1:0];
      end
    end
  end

  assign Idle    = (state_q == S_IDLE);
  assign Busy    = (state_q == S_RUN) || (state_q == S_FIX);
  assign Done    = (state_q == S_DONE);
  assign Produto = produto_q;

endmodule : mult_seq_param

// File: tb/tb_mult_seq_param.sv
// Self-checking bench: three builds (W=8/16/32) driven with directed and
// random operations, compared against a plain-arithmetic product model.
module tb_mult_seq_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  st_v, sg_v, ab_v;
  logic [31:0] a_in [3];
  logic [31:0] b_in [3];
  logic [2:0]  idle_v, busy_v, done_v;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [63:0] p32;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  mult_seq_param #(.W(8)) u_w8 (
    .Clk(clk), .Reset(rst_n), .St(st_v[0]), .Signed(sg_v[0]), .Abort(ab_v[0]),
    .Multiplicando(a_in[0][7:0]), .Multiplicador(b_in[0][7:0]),
    .Idle(idle_v[0]), .Busy(busy_v[0]), .Done(done_v[0]), .Produto(p8)
  );

  mult_seq_param #(.W(16)) u_w16 (
    .Clk(clk), .Reset(rst_n), .St(st_v[1]), .Signed(sg_v[1]), .Abort(ab_v[1]),
    .Multiplicando(a_in[1][15:0]), .Multiplicador(b_in[1][15:0]),
    .Idle(idle_v[1]), .Busy(busy_v[1]), .Done(done_v[1]), .Produto(p16)
  );

  mult_seq_param #(.W(32)) u_w32 (
    .Clk(clk), .Reset(rst_n), .St(st_v[2]), .Signed(sg_v[2]), .Abort(ab_v[2]),
    .Multiplicando(a_in[2]), .Multiplicador(b_in[2]),
    .Idle(idle_v[2]), .Busy(busy_v[2]), .Done(done_v[2]), .Produto(p32)
  );

  function automatic int width_of(input int sel);
    return 8 << sel;
  endfunction

  function automatic logic [63:0] prod_of(input int sel);
    case (sel)
      0:       return {48'b0, p8};
      1:       return {32'b0, p16};
      default: return p32;
    endcase
  endfunction

  function automatic logic [2:0] flags_of(input int sel);
    return {idle_v[sel], busy_v[sel], done_v[sel]};
  endfunction

  // Reference: sign- or zero-extend to 64 bits, multiply, keep 2*w bits
  function automatic logic [63:0] ref_mul(input int w, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m, pm, ax, bx;
    m  = (w == 32) ? 64'hFFFF_FFFF : ((64'd1 << w) - 64'd1);
    pm = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    ax = {32'b0, a} & m;
    bx = {32'b0, b} & m;
    if (sgn && ax[w-1]) ax = ax | ~m;
    if (sgn && bx[w-1]) bx = bx | ~m;
    return (ax * bx) & pm;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation; entered and left just after a falling edge.
  // Also pokes St during RUN and during DONE (both must be ignored) and
  // scrambles operands/mode after acceptance (must have no effect).
  task automatic run_op(input int sel, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic with_abort,
                        input string tag, output logic [63:0] prod);
    int          w, lat, limit;
    bit          seen;
    logic [63:0] exp_p;
    w     = width_of(sel);
    exp_p = ref_mul(w, sgn, a, b);
    limit = 4 * w + 20;
    chk({tag, "_ready"}, 64'(idle_v[sel]), 64'd1);
    st_v[sel] = 1'b1; sg_v[sel] = sgn; a_in[sel] = a; b_in[sel] = b;
    ab_v[sel] = with_abort;
    @(posedge clk); #1;
    st_v[sel] = 1'b0; ab_v[sel] = 1'b0;
    a_in[sel] = $urandom; b_in[sel] = $urandom; sg_v[sel] = ~sgn;
    lat = 0; seen = 1'b0;
    while (!seen && lat < limit) begin
      @(negedge clk);
      lat++;
      if (done_v[sel]) seen = 1'b1;
      else if (lat == 3) st_v[sel] = 1'b1;
      else if (lat == 4) st_v[sel] = 1'b0;
    end
    st_v[sel] = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(w + 2));
    prod = prod_of(sel);
    chk({tag, "_product"}, prod, exp_p);
    st_v[sel] = 1'b1;
    @(negedge clk);
    st_v[sel] = 1'b0;
    chk({tag, "_idle_after"}, 64'(flags_of(sel)), 64'(3'b100));
    chk({tag, "_held"}, prod_of(sel), exp_p);
  endtask

  initial begin
    logic [63:0] p;
    bit          seen;
    rst_n = 1'b0;
    st_v = '0; sg_v = '0; ab_v = '0;
    for (int i = 0; i < 3; i++) begin a_in[i] = '0; b_in[i] = '0; end
    #1;
    chk("reset_flags", 64'({idle_v, busy_v, done_v}), 64'(9'b111_000_000));
    chk("reset_produto", prod_of(1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed W=16 cases with known products
    run_op(1, 1'b0, 32'd3, 32'd5, 1'b0, "u3x5", p);
    chk("u3x5_const", p, 64'h0000_000F);
    run_op(1, 1'b0, 32'hFFFF, 32'hFFFF, 1'b0, "uffff", p);
    chk("uffff_const", p, 64'hFFFE_0001);
    run_op(1, 1'b1, 32'hFFFF, 32'hFFFF, 1'b0, "sm1m1", p);
    chk("sm1m1_const", p, 64'h0000_0001);
    run_op(1, 1'b1, 32'h8000, 32'h8000, 1'b0, "smin2", p);
    chk("smin2_const", p, 64'h4000_0000);
    run_op(1, 1'b1, 32'hFFFD, 32'h0005, 1'b0, "sm3x5", p);
    chk("sm3x5_const", p, 64'hFFFF_FFF1);

    // Abort 7 cycles into RUN: back to IDLE, no Done, old product kept
    st_v[1] = 1'b1; sg_v[1] = 1'b1; a_in[1] = 32'h1234; b_in[1] = 32'h5678;
    @(posedge clk); #1;
    st_v[1] = 1'b0;
    repeat (7) @(negedge clk);
    ab_v[1] = 1'b1;
    @(posedge clk); #1;
    ab_v[1] = 1'b0;
    @(negedge clk);
    chk("abort_flags", 64'(flags_of(1)), 64'(3'b100));
    chk("abort_produto", prod_of(1), 64'hFFFF_FFF1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done_v[1]) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    // Zero operand still runs the full W iterations
    run_op(1, 1'b1, 32'h0, 32'h1234, 1'b0, "zero", p);
    chk("zero_const", p, 64'd0);
    // Abort together with St in IDLE: St wins
    run_op(1, 1'b0, 32'd7, 32'd6, 1'b1, "abort_idle", p);
    chk("abort_idle_const", p, 64'd42);

    // Reset low mid-RUN clears everything without waiting for a clock edge
    st_v[1] = 1'b1; sg_v[1] = 1'b0; a_in[1] = 32'h00AB; b_in[1] = 32'h00CD;
    @(posedge clk); #1;
    st_v[1] = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_flags", 64'(flags_of(1)), 64'(3'b100));
    chk("midrun_reset_produto", prod_of(1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random signed/unsigned pairs for each build
    for (int sel = 0; sel < 3; sel++) begin
      for (int n = 0; n < 120; n++) begin
        run_op(sel, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0,
               $sformatf("rnd_w%0d_%0d", width_of(sel), n), p);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_mult_seq_param
